shifter_pipe: RTL

Parametrised, pipelined shift/rotate unit that generalises the team's 8-bit combinational shifter to any power-of-two width. It adds arithmetic shift right, valid/ready flow control, and optional zero/carry flags. It sits between operand registers and the ALU result mux. It accepts one operation per cycle and returns results in order after a fixed latency.

---
 rtl/shifter_pkg.sv | 27 ++
 rtl/shifter_stage.sv | 90 +++++++++
 rtl/shifter_pipe.sv | 82 ++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// shifter_pkg: shared types for the pipelined shift/rotate unit.
//   - opcode_t and the OP_* opcode encodings
//   - payload_t: per-stage pipeline payload sized for the widest supported
//     configuration (64-bit data, 6-bit amount); narrower instances use the
//     low bits and hold the rest at zero.
package shifter_pkg;

  localparam int unsigned MAX_W     = 64;
  localparam int unsigned MAX_AMT_W = 6;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ROL = 3'b000;
  localparam opcode_t OP_SHL = 3'b001;
  localparam opcode_t OP_ROR = 3'b010;
  localparam opcode_t OP_SHR = 3'b011;
  localparam opcode_t OP_ASR = 3'b100;

  typedef struct packed {
    logic                 valid;
    opcode_t              op;
    logic [MAX_AMT_W-1:0] amt;
    logic                 carry;
    logic [MAX_W-1:0]     data;
  } payload_t;

endpackage

// File: rtl/shifter_stage.sv
// shifter_stage: one registered stage of the log shifter.
// Shifts/rotates the payload data by 2^K when amount bit K is set, otherwise
// passes it. Stage 0 also computes the carry flag from the original operand
// and full amount (only when SHIFTER_FLAGS_EN is defined; otherwise carry is 0).
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (clears the register)
//   en_i        advance enable; register holds when low
//   d_i         incoming payload
//   q_o         registered payload
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned K     = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en_i,
  input  payload_t d_i,
  output payload_t q_o
);
  localparam int unsigned AMT_W = $clog2(WIDTH);
  localparam int unsigned S     = 1 << K;

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             carry_n;
  payload_t         q_d;
  payload_t         q_q;
  logic             unused_in;

  assign x         = d_i.data[WIDTH-1:0];
  assign unused_in = ^d_i;

  if (K == 0) begin : g_carry
`ifdef SHIFTER_FLAGS_EN
    logic [AMT_W-1:0] n;
    logic [AMT_W-1:0] li;
    logic [AMT_W-1:0] ri;
    // Modular AMT_W-bit arithmetic: li = WIDTH-n, ri = n-1.
    // Left ops lose bit WIDTH-n last; right ops lose bit n-1 last.
    always_comb begin
      n       = d_i.amt[AMT_W-1:0];
      li      = '0 - n;
      ri      = n - AMT_W'(1);
      carry_n = 1'b0;
      if (n != '0) begin
        case (d_i.op)
          OP_ROL, OP_SHL:         carry_n = x[li];
          OP_ROR, OP_SHR, OP_ASR: carry_n = x[ri];
          default:                carry_n = 1'b0;
        endcase
      end
    end
`else
    assign carry_n = 1'b0;
`endif
  end else begin : g_carry_pass
    assign carry_n = d_i.carry;
  end

  always_comb begin
    y = x;
    if (d_i.amt[K]) begin
      case (d_i.op)
        OP_ROL:  y = (x << S) | (x >> (WIDTH - S));
        OP_SHL:  y = x << S;
        OP_ROR:  y = (x >> S) | (x << (WIDTH - S));
        OP_SHR:  y = x >> S;
        OP_ASR:  y = $unsigned($signed(x) >>> S);
        default: y = x;
      endcase
    end
    q_d                 = d_i;
    q_d.data            = '0;
    q_d.data[WIDTH-1:0] = y;
    q_d.carry           = carry_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined shift/rotate unit, AMT_W = $clog2(WIDTH) stages.
// Opcodes ROL/SHL/ROR/SHR/ASR; other opcodes pass data through, carry 0.
// Results return in order AMT_W cycles after acceptance; the whole pipe
// (bubbles included) advances unless the output is stalled.
// Optional feature macro: SHIFTER_FLAGS_EN adds out_zero / out_carry.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready = not stalled)
//   in_data, in_amount, in_opcode  operand, distance, operation
//   out_valid/out_ready   result handshake
//   out_data              result
//   out_zero, out_carry   result==0, last bit shifted out (flags build only)
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  opcode_t          in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);
  logic     advance;
  payload_t pl_in;
  payload_t pl_q [AMT_W];
  payload_t pl_tail;
  logic     unused_tail;

  assign advance  = ~(out_valid & ~out_ready);
  assign in_ready = advance;

  always_comb begin
    pl_in                 = '0;
    pl_in.valid           = in_valid;
    pl_in.op              = in_opcode;
    pl_in.amt[AMT_W-1:0]  = in_amount;
    pl_in.data[WIDTH-1:0] = in_data;
  end

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    payload_t stage_in;
    if (k == 0) begin : g_first
      assign stage_in = pl_in;
    end else begin : g_next
      assign stage_in = pl_q[k-1];
    end
    shifter_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (advance),
      .d_i   (stage_in),
      .q_o   (pl_q[k])
    );
  end

  assign pl_tail     = pl_q[AMT_W-1];
  assign unused_tail = ^pl_tail;
  assign out_valid   = pl_tail.valid;
  assign out_data    = pl_tail.data[WIDTH-1:0];

`ifdef SHIFTER_FLAGS_EN
  // Zero is decoded from the final stage register, so it is as stable as out_data.
  assign out_zero  = ~|pl_tail.data[WIDTH-1:0];
  assign out_carry = pl_tail.carry;
`endif

endmodule
